axis_fir_coeff_sched: RTL and testbench

Coefficient scheduler for the AXI-stream FIR datapath. Accepts a new tap set on a configuration stream into a shadow bank. Holds it until the filter is between packets and fully drained, then swaps it atomically into the active tap vector that drives the FIR. It also gates the sample-input handshake so no packet is ever filtered with a mix of old and new taps.

---
 rtl/axis_fir_coeff_sched.sv | 126 ++++++++++++
 tb/tb_axis_fir_coeff_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fir_coeff_sched.sv
// Coefficient scheduler for the AXI-stream FIR datapath.
// Collects a tap set into a shadow bank, waits until the filter is between
// packets with nothing in flight, then swaps the whole set into the active
// tap vector. The sample handshake is gated so no packet ever sees mixed taps.
module axis_fir_coeff_sched #(
    parameter int NUM_TAPS     = 2,
    parameter int TAP_WIDTH    = 3,
    parameter logic [NUM_TAPS*TAP_WIDTH-1:0] RESET_TAPS = {3'b010, 3'b001},
    parameter int MAX_INFLIGHT = 4,
    parameter int IDX_WIDTH    = $clog2(NUM_TAPS),
    parameter int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TAP_WIDTH-1:0]          s_cfg_tdata,
    input  logic                          s_cfg_tvalid,
    input  logic                          s_cfg_tlast,
    output logic                          s_cfg_tready,
    input  logic                          in_tvalid,
    input  logic                          in_tlast,
    output logic                          in_tready,
    output logic                          fir_tvalid,
    input  logic                          fir_tready,
    input  logic                          out_last_fire,
    output logic [NUM_TAPS*TAP_WIDTH-1:0] taps,
    output logic                          swap_done,
    output logic                          cfg_err
);
    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_SWAP} state_t;

    state_t                               state_q;
    logic [IDX_WIDTH-1:0]                 idx_q;
    logic [NUM_TAPS-1:0][TAP_WIDTH-1:0]   shadow_q;
    logic [NUM_TAPS-1:0][TAP_WIDTH-1:0]   taps_q;
    logic                                 cfg_err_q;
    logic                                 pkt_open_q, pkt_open_d;
    logic [CNT_WIDTH-1:0]                 inflight_q, inflight_d;

    logic gate;
    logic in_fire;
    logic cfg_fire;
    logic last_idx;
    logic inc, dec;

    // Gate only between packets: either a swap is coming or the FIR is full.
    assign gate      = !pkt_open_q &&
                       (state_q != S_IDLE || inflight_q == CNT_WIDTH'(MAX_INFLIGHT));
    assign in_tready  = fir_tready && !gate;
    assign fir_tvalid = in_tvalid && !gate;
    assign in_fire    = in_tvalid && in_tready;

    assign s_cfg_tready = (state_q == S_IDLE);
    assign cfg_fire     = s_cfg_tvalid && s_cfg_tready;
    assign last_idx     = (idx_q == IDX_WIDTH'(NUM_TAPS - 1));

    assign taps      = taps_q;
    assign swap_done = (state_q == S_SWAP);
    assign cfg_err   = cfg_err_q;

    // Packet-open flag and in-flight packet count; a stray out_last_fire at zero is dropped.
    always_comb begin
        pkt_open_d = pkt_open_q;
        inflight_d = inflight_q;
        inc        = in_fire && in_tlast;
        dec        = out_last_fire && (inflight_q != '0);
        if (in_fire)
            pkt_open_d = !in_tlast;
        case ({inc, dec})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Packet tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_open_q <= 1'b0;
            inflight_q <= '0;
        end else begin
            pkt_open_q <= pkt_open_d;
            inflight_q <= inflight_d;
        end
    end

    // Load / pending / swap FSM; active taps only ever change on the SWAP edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            taps_q    <= RESET_TAPS;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cfg_fire) begin
                        if (last_idx && s_cfg_tlast) begin
                            shadow_q[idx_q] <= s_cfg_tdata;
                            idx_q           <= '0;
                            state_q         <= S_PENDING;
                        end else if (last_idx || s_cfg_tlast) begin
                            // Wrong length: drop the partial set and start over.
                            cfg_err_q <= 1'b1;
                            idx_q     <= '0;
                            shadow_q  <= '0;
                        end else begin
                            shadow_q[idx_q] <= s_cfg_tdata;
                            idx_q           <= idx_q + 1'b1;
                        end
                    end
                end
                S_PENDING: begin
                    if (!pkt_open_q && inflight_q == '0)
                        state_q <= S_SWAP;
                end
                S_SWAP: begin
                    taps_q  <= shadow_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_fir_coeff_sched.sv
// Bench for axis_fir_coeff_sched: directed scenarios followed by random
// sample/config traffic, with a scoreboard of expected tap sets and errors.
module tb_axis_fir_coeff_sched;
    localparam int         MI       = 4;
    localparam logic [5:0] RST_TAPS = 6'b010_001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] s_cfg_tdata = '0;
    logic       s_cfg_tvalid = 1'b0, s_cfg_tlast = 1'b0, s_cfg_tready;
    logic       in_tvalid = 1'b0, in_tlast = 1'b0, in_tready;
    logic       fir_tvalid, fir_tready = 1'b1;
    logic       out_last_fire;
    logic [5:0] taps;
    logic       swap_done, cfg_err;

    logic olf_en = 1'b0, olf_rand = 1'b0, olf_manual = 1'b0;
    assign out_last_fire = olf_en ? olf_rand : olf_manual;

    int         ntests = 0, nfail = 0;
    logic [5:0] exp_taps_q[$];
    int         exp_err_q[$];
    int         tb_infl = 0;
    bit         tb_open = 1'b0;

    axis_fir_coeff_sched dut (
        .clk(clk), .rst(rst),
        .s_cfg_tdata(s_cfg_tdata), .s_cfg_tvalid(s_cfg_tvalid),
        .s_cfg_tlast(s_cfg_tlast), .s_cfg_tready(s_cfg_tready),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .fir_tvalid(fir_tvalid), .fir_tready(fir_tready),
        .out_last_fire(out_last_fire), .taps(taps),
        .swap_done(swap_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input logic [2:0] d, input logic l);
        at_edge();
        s_cfg_tdata  = d;
        s_cfg_tlast  = l;
        s_cfg_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_cfg_tready) return;
            at_edge();
        end
        chk("cfg_accept_timeout", s_cfg_tready, 1);
    endtask

    task automatic cfg_off();
        at_edge();
        s_cfg_tvalid = 1'b0;
        s_cfg_tlast  = 1'b0;
    endtask

    task automatic wait_swap(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (swap_done) return;
        end
        chk("swap_timeout", swap_done, 1);
    endtask

    // FIR emulator: completes outstanding packets at random.
    always @(posedge clk) begin
        #1;
        olf_rand = !rst && olf_en && (tb_infl > 0) && ($urandom_range(2) == 0);
    end

    // Monitor: scoreboard for swaps and errors plus handshake invariants.
    logic [5:0] last_taps, pkt_taps, chk_val;
    bit         pend_chk = 1'b0, prev_swap = 1'b0;
    always @(negedge clk) begin
        bit dec;
        if (rst) begin
            tb_open   = 1'b0;
            tb_infl   = 0;
            pend_chk  = 1'b0;
            prev_swap = 1'b0;
            last_taps = taps;
            exp_taps_q.delete();
            exp_err_q.delete();
        end else begin
            if (pend_chk) begin
                chk("swap_taps", taps, chk_val);
                pend_chk = 1'b0;
            end
            if (taps !== last_taps) chk("taps_change_only_after_swap", prev_swap, 1);
            last_taps = taps;
            if (swap_done) begin
                chk("swap_expected", exp_taps_q.size() > 0, 1);
                if (exp_taps_q.size() > 0) begin
                    chk_val  = exp_taps_q.pop_front();
                    pend_chk = 1'b1;
                end
                chk("swap_drained", (tb_open || tb_infl != 0), 0);
                chk("swap_gate", in_tready, 0);
            end
            if (cfg_err) begin
                chk("cfg_err_expected", exp_err_q.size() > 0, 1);
                if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
            end
            if (tb_open)
                chk("no_mid_pkt_gate", in_tready, fir_tready);
            else if (tb_infl < MI && exp_taps_q.size() == 0 && !swap_done)
                chk("idle_no_bubble", in_tready, fir_tready);
            dec = out_last_fire && (tb_infl > 0);
            if (in_tvalid && in_tready) begin
                if (tb_open) chk("pkt_taps_stable", taps, pkt_taps);
                else pkt_taps = taps;
                tb_open = !in_tlast;
                if (in_tlast) tb_infl++;
            end
            if (dec) tb_infl--;
            prev_swap = swap_done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int         beats_left = 0, cfg_pos = 0, cfg_kind = 0;
        logic [2:0] cd0 = '0, cd1 = '0;
        bit         stopping = 1'b0;

        // Reset
        repeat (2) at_edge();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_taps", taps, RST_TAPS);
        chk("rst_cfg_ready", s_cfg_tready, 1);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_in_tready", in_tready, 1);
        chk("rst_fir_tvalid", fir_tvalid, 0);
        at_edge();
        in_tvalid = 1'b1; fir_tready = 1'b0;
        @(negedge clk);
        chk("rst_fir_tvalid_pass", fir_tvalid, 1);
        chk("rst_in_tready_follow", in_tready, 0);
        at_edge();
        in_tvalid = 1'b0; fir_tready = 1'b1;

        // Idle swap: {1, -2}
        drive_cfg(3'b001, 1'b0);
        drive_cfg(3'b110, 1'b1);
        exp_taps_q.push_back(6'b110_001);
        cfg_off();
        @(negedge clk);
        chk("idle_pending_no_swap", swap_done, 0);
        chk("idle_pending_cfg_blocked", s_cfg_tready, 0);
        @(negedge clk);
        chk("idle_swap_latency", swap_done, 1);
        @(negedge clk);
        chk("idle_new_taps", taps, 6'b110_001);
        chk("idle_ungated", in_tready, 1);

        // Mid-packet hold: 8-beat packet, taps loaded on beats 2..3
        for (int b = 0; b < 8; b++) begin
            at_edge();
            in_tvalid    = 1'b1;
            in_tlast     = (b == 7);
            s_cfg_tvalid = (b == 2 || b == 3);
            s_cfg_tdata  = (b == 2) ? 3'b011 : 3'b101;
            s_cfg_tlast  = (b == 3);
            @(negedge clk);
            chk("mid_pkt_ready", in_tready, 1);
            if (b == 2 || b == 3) chk("mid_pkt_cfg_ready", s_cfg_tready, 1);
        end
        exp_taps_q.push_back(6'b101_011);
        at_edge();
        s_cfg_tvalid = 1'b0; s_cfg_tlast = 1'b0;
        in_tvalid = 1'b1; in_tlast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pkt2_stalled", in_tready, 0);
            chk("no_swap_while_inflight", swap_done, 0);
            chk("old_taps_held", taps, 6'b110_001);
            at_edge();
        end
        olf_manual = 1'b1;
        @(negedge clk);
        chk("pkt2_stalled_olf", in_tready, 0);
        at_edge();
        olf_manual = 1'b0;
        @(negedge clk);
        chk("hold_swap_not_yet", swap_done, 0);
        chk("hold_still_stalled", in_tready, 0);
        @(negedge clk);
        chk("hold_swap_done", swap_done, 1);
        chk("hold_swap_gated", in_tready, 0);
        @(negedge clk);
        chk("hold_reopen", in_tready, 1);
        chk("hold_new_taps", taps, 6'b101_011);
        at_edge();
        in_tlast = 1'b1;
        @(negedge clk);
        chk("pkt2_last_accept", in_tready, 1);
        at_edge();
        in_tvalid = 1'b0; in_tlast = 1'b0; olf_manual = 1'b1;
        at_edge();
        olf_manual = 1'b0;

        // Malformed set: tlast on the first beat
        drive_cfg(3'b111, 1'b1);
        exp_err_q.push_back(1);
        cfg_off();
        @(negedge clk);
        chk("bad_cfg_err", cfg_err, 1);
        @(negedge clk);
        chk("bad_cfg_err_once", cfg_err, 0);
        chk("bad_taps_kept", taps, 6'b101_011);
        chk("bad_still_idle", s_cfg_tready, 1);
        drive_cfg(3'b010, 1'b0);
        drive_cfg(3'b011, 1'b1);
        exp_taps_q.push_back(6'b011_010);
        cfg_off();
        wait_swap(10);
        @(negedge clk);
        chk("bad_then_good_taps", taps, 6'b011_010);

        // Back-pressure: four one-beat packets fill the FIR
        for (int k = 0; k < 4; k++) begin
            at_edge();
            in_tvalid = 1'b1; in_tlast = 1'b1;
            @(negedge clk);
            chk("bp_accept", in_tready, 1);
        end
        at_edge();
        @(negedge clk);
        chk("bp_full", in_tready, 0);
        chk("bp_fir_tvalid", fir_tvalid, 0);
        at_edge();
        olf_manual = 1'b1;
        @(negedge clk);
        chk("bp_still_full", in_tready, 0);
        at_edge();
        olf_manual = 1'b0;
        @(negedge clk);
        chk("bp_reopen", in_tready, 1);
        at_edge();
        in_tvalid = 1'b0; in_tlast = 1'b0;
        repeat (4) begin
            olf_manual = 1'b1;
            at_edge();
        end
        olf_manual = 1'b0;

        // Reset while a set is pending behind an in-flight packet
        at_edge();
        in_tvalid = 1'b1; in_tlast = 1'b1;
        @(negedge clk);
        at_edge();
        in_tvalid = 1'b0; in_tlast = 1'b0;
        drive_cfg(3'b001, 1'b0);
        drive_cfg(3'b111, 1'b1);
        exp_taps_q.push_back(6'b111_001);
        cfg_off();
        repeat (3) begin
            @(negedge clk);
            chk("pend_cfg_blocked", s_cfg_tready, 0);
            chk("pend_no_swap", swap_done, 0);
        end
        at_edge();
        rst = 1'b1;
        at_edge();
        at_edge();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pend_taps", taps, RST_TAPS);
        chk("rst_pend_idle", s_cfg_tready, 1);
        repeat (6) begin
            @(negedge clk);
            chk("rst_pend_no_swap", swap_done, 0);
        end

        // Random traffic
        olf_en = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc >= 4000) stopping = 1'b1;
            if (stopping && beats_left == 0 && cfg_pos == 0 &&
                exp_taps_q.size() == 0 && tb_infl == 0) break;
            at_edge();
            fir_tready = ($urandom_range(3) != 0);
            if (beats_left == 0 && !stopping && $urandom_range(2) == 0)
                beats_left = $urandom_range(5, 1);
            in_tvalid = (beats_left > 0);
            in_tlast  = (beats_left == 1);
            if (cfg_pos == 0 && !stopping && $urandom_range(24) == 0) begin
                cfg_kind = $urandom_range(4);
                if (cfg_kind > 2) cfg_kind = 0;
                cd0 = 3'($urandom);
                cd1 = 3'($urandom);
                cfg_pos = 1;
            end
            s_cfg_tvalid = (cfg_pos > 0);
            s_cfg_tdata  = (cfg_pos == 2) ? cd1 : cd0;
            s_cfg_tlast  = (cfg_kind == 1) || (cfg_kind == 0 && cfg_pos == 2);
            @(negedge clk);
            if (in_tvalid && in_tready) beats_left--;
            if (s_cfg_tvalid && s_cfg_tready) begin
                if (cfg_kind == 1 || cfg_pos == 2) begin
                    if (cfg_kind == 0) exp_taps_q.push_back({cd1, cd0});
                    else exp_err_q.push_back(1);
                    cfg_pos = 0;
                end else begin
                    cfg_pos = 2;
                end
            end
        end
        at_edge();
        in_tvalid = 1'b0; in_tlast = 1'b0; s_cfg_tvalid = 1'b0; s_cfg_tlast = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain_swaps_done", exp_taps_q.size(), 0);
        chk("drain_errs_done", exp_err_q.size(), 0);
        chk("drain_idle", s_cfg_tready, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
